// File: rtl/vs_rf_if.sv
// Register-file port bundle: read ports, writeback port and issue/scoreboard port.
// The decode/writeback side uses master and the register file uses slave.
interface vs_rf_if #(
  parameter int LANES = 16,
  parameter int W     = 32,
  parameter int AW    = 4
);
  logic                 init_done;
  logic [AW-1:0]        ra1;
  logic [AW-1:0]        ra2;
  logic                 rsel_v;
  logic [LANES*W-1:0]   rd1;
  logic [LANES*W-1:0]   rd2;
  logic                 busy1;
  logic                 busy2;
  logic                 we;
  logic                 wsel_v;
  logic [AW-1:0]        wa;
  logic [LANES-1:0]     wmask;
  logic [LANES*W-1:0]   wd;
  logic [W-1:0]         pc_in;
  logic                 issue_valid;
  logic [AW-1:0]        issue_addr;
  logic                 issue_v;

  modport master (
    input  init_done, rd1, rd2, busy1, busy2,
    output ra1, ra2, rsel_v, we, wsel_v, wa, wmask, wd,
    output pc_in, issue_valid, issue_addr, issue_v
  );

  modport slave (
    output init_done, rd1, rd2, busy1, busy2,
    input  ra1, ra2, rsel_v, we, wsel_v, wa, wmask, wd,
    input  pc_in, issue_valid, issue_addr, issue_v
  );
endinterface

// File: rtl/vs_regfile_sb.sv
// Vector/scalar register file with per-lane write masks, a post-reset clear engine and a pending-write scoreboard.
// Optional write-to-read forwarding is enabled by defining VS_RF_BYPASS_EN.
module vs_regfile_sb #(
  parameter int LANES = 16,
  parameter int W     = 32,
  parameter int NV    = 16,
  parameter int NS    = 16,
  parameter int AW    = 4
) (
  input  logic     clk,
  input  logic     rst,
  vs_rf_if.slave   bus
);
  localparam int NMAX = (NV > NS) ? NV : NS;
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int TOP  = (LANES - 1) * W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                done_q;
  logic [LANES*W-1:0]  vreg [NV];
  logic [W-1:0]        sreg [NS];
  logic [NV-1:0]       pv;
  logic [NS-1:0]       ps;
  logic                rdy;
  logic                wr;
  logic                iss;

  assign rdy = (state == READY);
  assign wr  = rdy & bus.we;
  assign iss = rdy & bus.issue_valid;
  assign bus.init_done = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (32'(cnt) == NMAX - 1) begin
            state  <= READY;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // Contents have no reset; the clear engine zeroes one slot per cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NV; i++) begin
      if (state == CLEAR && 32'(cnt) == i) begin
        vreg[i] <= '0;
      end else if (wr && bus.wsel_v && 32'(bus.wa) == i) begin
        for (int l = 0; l < LANES; l++) begin
          if (bus.wmask[l]) vreg[i][l*W +: W] <= bus.wd[l*W +: W];
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (state == CLEAR && 32'(cnt) == i) begin
        sreg[i] <= '0;
      end else if (wr && !bus.wsel_v && 32'(bus.wa) == i && i != NS - 1) begin
        sreg[i] <= bus.wd[TOP +: W];
      end
    end
  end

  // Issue is applied after the write clear so a new producer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      ps <= '0;
    end else begin
      for (int i = 0; i < NV; i++) begin
        if (wr && bus.wsel_v && 32'(bus.wa) == i) pv[i] <= 1'b0;
        if (iss && bus.issue_v && 32'(bus.issue_addr) == i) pv[i] <= 1'b1;
      end
      for (int i = 0; i < NS; i++) begin
        if (wr && !bus.wsel_v && 32'(bus.wa) == i) ps[i] <= 1'b0;
        if (iss && !bus.issue_v && 32'(bus.issue_addr) == i) ps[i] <= 1'b1;
      end
    end
  end

  function automatic logic [LANES*W-1:0] rdata(
    input logic [AW-1:0] a,
    input logic          v,
    input logic [W-1:0]  pc
  );
    logic [LANES*W-1:0] d;
    d = '0;
    if (v) begin
      for (int i = 0; i < NV; i++)
        if (32'(a) == i) d = vreg[i];
    end else begin
      for (int i = 0; i < NS; i++)
        if (32'(a) == i) d[TOP +: W] = (i == NS - 1) ? pc : sreg[i];
    end
    return d;
  endfunction

  function automatic logic rbusy(
    input logic [AW-1:0] a,
    input logic          v
  );
    logic b;
    b = 1'b0;
    if (v) begin
      for (int i = 0; i < NV; i++)
        if (32'(a) == i) b = pv[i];
    end else begin
      for (int i = 0; i < NS; i++)
        if (32'(a) == i) b = ps[i];
    end
    return b;
  endfunction

`ifdef VS_RF_BYPASS_EN
  function automatic logic fwd_hit(
    input logic [AW-1:0] a,
    input logic          v
  );
    logic ok;
    ok = v ? (32'(a) < NV) : (32'(a) < NS - 1);
    return wr && (bus.wsel_v == v) && (bus.wa == a) && ok;
  endfunction

  function automatic logic iss_hit(
    input logic [AW-1:0] a,
    input logic          v
  );
    return iss && (bus.issue_v == v) && (bus.issue_addr == a);
  endfunction

  function automatic logic [LANES*W-1:0] merge(
    input logic [LANES*W-1:0] d,
    input logic               v
  );
    logic [LANES*W-1:0] m;
    m = d;
    if (v) begin
      for (int l = 0; l < LANES; l++)
        if (bus.wmask[l]) m[l*W +: W] = bus.wd[l*W +: W];
    end else begin
      m[TOP +: W] = bus.wd[TOP +: W];
    end
    return m;
  endfunction
`endif

  always_comb begin
    bus.rd1   = '0;
    bus.rd2   = '0;
    bus.busy1 = 1'b0;
    bus.busy2 = 1'b0;
    if (rdy) begin
      bus.rd1   = rdata(bus.ra1, bus.rsel_v, bus.pc_in);
      bus.rd2   = rdata(bus.ra2, bus.rsel_v, bus.pc_in);
      bus.busy1 = rbusy(bus.ra1, bus.rsel_v);
      bus.busy2 = rbusy(bus.ra2, bus.rsel_v);
`ifdef VS_RF_BYPASS_EN
      if (fwd_hit(bus.ra1, bus.rsel_v)) begin
        bus.rd1 = merge(bus.rd1, bus.rsel_v);
        if (!iss_hit(bus.ra1, bus.rsel_v)) bus.busy1 = 1'b0;
      end
      if (fwd_hit(bus.ra2, bus.rsel_v)) begin
        bus.rd2 = merge(bus.rd2, bus.rsel_v);
        if (!iss_hit(bus.ra2, bus.rsel_v)) bus.busy2 = 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_vs_regfile_sb.sv
// Scoreboard bench for vs_regfile_sb: per-lane array model, directed plan then random traffic.
module tb_vs_regfile_sb;
  localparam int LANES = 16;
  localparam int W     = 32;
  localparam int NV    = 16;
  localparam int NS    = 16;
  localparam int AW    = 4;
  localparam int NMAX  = (NV > NS) ? NV : NS;
  localparam int TOP   = (LANES - 1) * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vs_rf_if #(.LANES(LANES), .W(W), .AW(AW)) bus ();

  vs_regfile_sb #(
    .LANES(LANES), .W(W), .NV(NV), .NS(NS), .AW(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [LANES*W-1:0] rd1;
    logic [LANES*W-1:0] rd2;
    logic               b1;
    logic               b2;
    logic               init;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  logic [W-1:0] vm [NV][LANES];
  logic [W-1:0] sm [NS];
  bit           pv [NV];
  bit           ps [NS];
  bit           ready;
  int           clear_left;

  task automatic chk(input string n, input logic [LANES*W-1:0] a,
                     input logic [LANES*W-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      pv[i] = 0;
      for (int l = 0; l < LANES; l++) vm[i][l] = '0;
    end
    for (int i = 0; i < NS; i++) begin
      ps[i] = 0;
      sm[i] = '0;
    end
    ready      = 0;
    clear_left = NMAX;
  endtask

  task automatic model_read(input int a, input bit v,
                            output logic [LANES*W-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (ready) begin
      if (v && a < NV) begin
        for (int l = 0; l < LANES; l++) d[l*W +: W] = vm[a][l];
        b = pv[a];
      end else if (!v && a < NS) begin
        d[TOP +: W] = (a == NS - 1) ? bus.pc_in : sm[a];
        b = ps[a];
      end
`ifdef VS_RF_BYPASS_EN
      if (bus.we && bus.wsel_v == v && int'(bus.wa) == a &&
          (v ? a < NV : a < NS - 1)) begin
        if (v) begin
          for (int l = 0; l < LANES; l++)
            if (bus.wmask[l]) d[l*W +: W] = bus.wd[l*W +: W];
        end else begin
          d[TOP +: W] = bus.wd[TOP +: W];
        end
        if (!(bus.issue_valid && bus.issue_v == v &&
              int'(bus.issue_addr) == a)) b = 1'b0;
      end
`endif
    end
  endtask

  task automatic model_edge();
    int a;
    if (rst) begin
      model_reset();
    end else if (!ready) begin
      clear_left--;
      if (clear_left == 0) ready = 1;
    end else begin
      a = int'(bus.wa);
      if (bus.we) begin
        if (bus.wsel_v && a < NV) begin
          for (int l = 0; l < LANES; l++)
            if (bus.wmask[l]) vm[a][l] = bus.wd[l*W +: W];
          pv[a] = 0;
        end else if (!bus.wsel_v && a < NS) begin
          if (a != NS - 1) sm[a] = bus.wd[TOP +: W];
          ps[a] = 0;
        end
      end
      a = int'(bus.issue_addr);
      if (bus.issue_valid) begin
        if (bus.issue_v && a < NV) pv[a] = 1;
        if (!bus.issue_v && a < NS) ps[a] = 1;
      end
    end
  endtask

  // Entered just after a rising edge; inputs are already driven.
  task automatic step();
    exp_t e;
    if (rst) model_reset();
    model_read(int'(bus.ra1), bus.rsel_v, e.rd1, e.b1);
    model_read(int'(bus.ra2), bus.rsel_v, e.rd2, e.b2);
    e.init = ready;
    q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rd1", bus.rd1, e.rd1);
      chk("rd2", bus.rd2, e.rd2);
      chk("busy1", {511'b0, bus.busy1}, {511'b0, e.b1});
      chk("busy2", {511'b0, bus.busy2}, {511'b0, e.b2});
      chk("init_done", {511'b0, bus.init_done}, {511'b0, e.init});
    end
  end

  task automatic idle();
    bus.we          = 1'b0;
    bus.issue_valid = 1'b0;
    bus.wmask       = '0;
  endtask

  task automatic set_rd(input int a1, input int a2, input bit v);
    bus.ra1    = AW'(a1);
    bus.ra2    = AW'(a2);
    bus.rsel_v = v;
  endtask

  task automatic set_wr(input int a, input bit v, input logic [LANES-1:0] m,
                        input logic [LANES*W-1:0] d);
    bus.we     = 1'b1;
    bus.wsel_v = v;
    bus.wa     = AW'(a);
    bus.wmask  = m;
    bus.wd     = d;
  endtask

  task automatic set_iss(input int a, input bit v);
    bus.issue_valid = 1'b1;
    bus.issue_addr  = AW'(a);
    bus.issue_v     = v;
  endtask

  function automatic logic [LANES*W-1:0] rand_wd();
    logic [LANES*W-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*W +: W] = $urandom;
    return d;
  endfunction

  logic [LANES*W-1:0] ramp;
  logic [LANES*W-1:0] sval;

  initial begin
    rst = 1'b1;
    bus.ra1 = '0; bus.ra2 = '0; bus.rsel_v = 1'b0;
    bus.wsel_v = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.pc_in = '0; bus.issue_addr = '0; bus.issue_v = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // Clear sequence with writes/issues that must be ignored
    set_rd(3, 3, 1'b1);
    set_wr(3, 1'b1, '1, rand_wd());
    set_iss(3, 1'b1);
    for (int i = 0; i < NMAX; i++) step();
    idle();
    step();

    // Masked vector write, then an empty mask
    for (int l = 0; l < LANES; l++) ramp[l*W +: W] = W'(l + 1);
    set_rd(2, 3, 1'b1);
    set_wr(2, 1'b1, 16'h00F0, ramp);
    step();
    set_wr(2, 1'b1, '0, rand_wd());
    step();
    idle();
    step();

    // Scalar write and PC alias
    sval = '0;
    sval[TOP +: W] = 32'd12;
    set_wr(5, 1'b0, '0, sval);
    step();
    idle();
    set_rd(5, 15, 1'b0);
    bus.pc_in = 32'h40;
    step();
    sval[TOP +: W] = 32'd99;
    set_wr(15, 1'b0, '0, sval);
    step();
    idle();
    step();

    // Scoreboard set / set-wins / clear
    set_rd(7, 7, 1'b1);
    set_iss(7, 1'b1);
    step();
    set_iss(7, 1'b1);
    set_wr(7, 1'b1, '1, rand_wd());
    step();
    idle();
    step();
    set_wr(7, 1'b1, '1, rand_wd());
    step();
    idle();
    step();

    // Same-cycle read/write of s3
    set_rd(3, 3, 1'b0);
    sval[TOP +: W] = 32'hAB;
    set_wr(3, 1'b0, '0, sval);
    step();
    idle();
    step();

    // Mid-operation reset
    set_rd(1, 2, 1'b1);
    set_wr(1, 1'b1, '1, rand_wd());
    set_iss(1, 1'b1);
    step();
    idle();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NMAX; i++) step();
    step();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      set_rd($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
      bus.we          = 1'($urandom);
      bus.wsel_v      = 1'($urandom);
      bus.wa          = AW'($urandom_range(0, 15));
      bus.wmask       = LANES'($urandom);
      bus.wd          = rand_wd();
      bus.pc_in       = $urandom;
      bus.issue_valid = ($urandom_range(0, 3) == 0);
      bus.issue_addr  = AW'($urandom_range(0, 15));
      bus.issue_v     = 1'($urandom);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vs_regfile_sb.md
Name: vs_regfile_sb

Overview:
- Parametrised vector/scalar register file for the SIMD core; successor to the fixed 16x16-lane design.
- Configurable lane count, element width and register counts.
- Adds per-lane write masks, a sequential post-reset clear engine with a ready flag, and a per-register pending-write scoreboard for hazard detection.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- LANES, 16, vector lanes per register.
- W, 32, bits per element.
- NV, 16, number of vector registers.
- NS, 16, number of scalar registers; index NS-1 is the PC alias.
- AW, 4, address width; must satisfy 2^AW >= max(NV,NS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- init_done  out  1  high once the clear sequence has finished.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rsel_v  in  1  read type for both ports; 1 = vector, 0 = scalar.
- rd1  out  LANES*W  read data, port 1; lane i = bits [i*W +: W].
- rd2  out  LANES*W  read data, port 2.
- busy1  out  1  pending flag of the register addressed by ra1/rsel_v.
- busy2  out  1  pending flag of the register addressed by ra2/rsel_v.
- we  in  1  write enable.
- wsel_v  in  1  write type; 1 = vector, 0 = scalar.
- wa  in  AW  write address.
- wmask  in  LANES  per-lane write enable for vector writes.
- wd  in  LANES*W  write data.
- pc_in  in  W  value returned for scalar register NS-1.
- issue_valid  in  1  marks register (issue_addr, issue_v) as pending.
- issue_addr  in  AW  address of the register being issued.
- issue_v  in  1  type of the register being issued; 1 = vector.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to CLEAR, clear counter = 0, init_done = 0.
  - All pending bits = 0.
  - Register contents are not reset directly; the clear engine zeroes them.
- CLEAR state, one register per cycle:
  - Each cycle: vector reg[cnt] <= 0 if cnt < NV; scalar reg[cnt] <= 0 if cnt < NS.
  - Counter then increments.
  - At cnt = max(NV,NS)-1, the FSM moves to READY next edge. Clear takes exactly max(NV,NS) cycles after rst deasserts.
  - init_done is registered: 1 from the first cycle in READY.
- While in CLEAR:
  - we and issue_valid are ignored.
  - rd1/rd2 = 0, busy1/busy2 = 0.
- rst asserted mid-clear or in READY: immediate return to CLEAR with counter 0.
- Reads (combinational, READY only):
  - Vector read: all lanes of vector reg[ra].
  - Scalar read: lane LANES-1 = scalar[ra] (or pc_in when ra = NS-1); all other lanes = 0.
  - Address >= NV (vector) or >= NS (scalar): read returns 0 and busy = 0.
- Writes (rising edge, READY, we=1):
  - Vector write: each lane i with wmask[i]=1 takes wd lane i; unmasked lanes hold. wmask = 0 means no change.
  - Scalar write: scalar[wa] <= wd lane LANES-1; wmask is ignored.
  - Write to scalar NS-1 or to an out-of-range address: data is discarded, but the pending bit is still cleared if it is in range.
- Scoreboard:
  - issue_valid sets pend[issue_v][issue_addr].
  - A write clears pend[wsel_v][wa].
  - Issue and write to the same register in the same cycle: set wins (new producer).
  - Issue to an out-of-range address: ignored.
  - busy reflects registered state only; no same-cycle bypass of the set/clear.
- Read/write same register, same cycle, without the optional feature: the read returns the old value; the new value is visible the next cycle.

Optional Feature:
- Macro VS_RF_BYPASS_EN.
- Defined:
  - If we=1 in READY and (wa, wsel_v) equals a read port's (ra, rsel_v) and the address is in range and writable, that port returns write data combinationally the same cycle.
  - Vector: masked lanes come from wd, unmasked lanes from storage. Scalar: lane LANES-1 comes from wd.
  - The matching busy output also reads 0 that cycle unless issue_valid targets the same register.
- Undefined: no forwarding; reads always return registered contents.

Test Plan:
- Clear sequence: rst pulse with NV=NS=16 -> init_done rises exactly 16 cycles after rst deasserts. During clear, we=1 to v3 is ignored; afterwards v3 reads all zero.
- Masked vector write: write v2 with wd lane i = i+1 and wmask=16'h00F0 -> next cycle v2 lanes 4..7 = 5..8, all other lanes 0. Second write with wmask=0 -> v2 unchanged.
- Scalar and PC alias: write s5 = 12 -> scalar read of ra1=5 gives lane15 = 12, lanes 0..14 = 0. pc_in = 0x40 with ra2=15 scalar -> lane15 = 0x40. Write to s15 has no effect.
- Scoreboard: issue v7 -> busy1=1 next cycle for ra1=7 vector. Same cycle, issue v7 plus a write to v7 -> stays busy. Later a write to v7 alone -> busy1=0 next cycle.
- Same-cycle read/write: write s3 = 0xAB while ra1=3 scalar -> rd1 lane15 = 0xAB that cycle with VS_RF_BYPASS_EN, old value 0 without it. Both builds show 0xAB the next cycle.
- Mid-operation reset: write v1, then assert rst for 1 cycle -> busy bits cleared, init_done=0, 16-cycle clear reruns, v1 reads 0 afterwards.
